// File: rtl/cube_pkg.sv
// Shared definitions for the object mover and the cube collision scanner:
// FSM encoding, scanner flag bit positions and cube world geometry.
package cube_pkg;

    typedef enum logic [1:0] {
        ST_PLAYER  = 2'd0,
        ST_SHELL   = 2'd1,
        ST_EXPLODE = 2'd2
    } mover_state_t;

    localparam int TOP_HIT   = 3;
    localparam int SUPPORT   = 2;
    localparam int LEFT_BLK  = 1;
    localparam int RIGHT_BLK = 0;

    localparam logic [17:0] CUBE_SIZE   = 18'h08000;
    localparam logic [17:0] TOP_CUBE_Y  = 18'h20000;
    localparam int          SCAN_PERIOD = 51;

    // Lower clamp for a widened velocity; the result always fits 12 bits.
    function automatic logic signed [11:0] vel_floor(
        input logic signed [12:0] v,
        input logic signed [11:0] vmin
    );
        logic signed [11:0] r;
        if (v < $signed({vmin[11], vmin})) begin
            r = vmin;
        end else begin
            r = v[11:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/object_mover_if.sv
// Shared object bus between the object mover (master) and the cube scanner
// (slave): object pose and mode out, sampled collision flags back.
interface object_mover_if;
    logic [17:0] object_x;
    logic [17:0] object_y;
    logic        id;
    logic        game_state;
    logic [3:0]  object_states_in;

    modport master (
        output object_x, object_y, id, game_state,
        input  object_states_in
    );

    modport slave (
        input  object_x, object_y, id, game_state,
        output object_states_in
    );
endinterface

// File: rtl/motion_integrator.sv
// One axis of motion: optional gravity with terminal clamp, optional clip of
// upward velocity, then a saturating position add with range flags.
module motion_integrator
    import cube_pkg::*;
#(
    parameter logic signed [11:0] GRAVITY = 12'sd64,
    parameter logic signed [11:0] VY_MIN  = -12'sd1024,
    parameter logic [17:0]        POS_MAX = 18'h3FFFF
) (
    input  logic [17:0]        pos,
    input  logic signed [11:0] vel,
    input  logic               grav_en,
    input  logic               clip_up,
    output logic signed [11:0] vel_next,
    output logic [17:0]        pos_next,
    output logic               under,
    output logic               over
);

    logic signed [12:0] vel_dec_s;
    logic signed [11:0] vel_pre_s;
    logic signed [19:0] sum_s;

    // Velocity update followed by a widened add so both bounds are visible.
    always_comb begin
        vel_dec_s = $signed({vel[11], vel}) - $signed({GRAVITY[11], GRAVITY});
        if (grav_en) begin
            vel_pre_s = vel_floor(vel_dec_s, VY_MIN);
        end else begin
            vel_pre_s = vel;
        end
        if (clip_up && (vel_pre_s > 12'sd0)) begin
            vel_next = 12'sd0;
        end else begin
            vel_next = vel_pre_s;
        end
        sum_s = $signed({2'b00, pos}) + $signed({{8{vel_next[11]}}, vel_next});
        under = (sum_s < 20'sd0);
        over  = (sum_s > $signed({2'b00, POS_MAX}));
        if (under) begin
            pos_next = 18'h00000;
        end else if (over) begin
            pos_next = POS_MAX;
        end else begin
            pos_next = sum_s[17:0];
        end
    end

endmodule

// File: rtl/object_mover.sv
// Drives the shared object bus: integrates player walking/jumping once per
// frame, flies shells, and requests explosion scans on shell impact.
module object_mover
    import cube_pkg::*;
#(
    parameter logic [17:0]        STEP_X         = 18'h00400,
    parameter logic signed [11:0] GRAVITY        = 12'sd64,
    parameter logic signed [11:0] VY_MIN         = -12'sd1024,
    parameter logic signed [11:0] JUMP_VY        = 12'sd1536,
    parameter logic signed [11:0] SHELL_VX       = 12'sd768,
    parameter logic signed [11:0] SHELL_VY       = 12'sd1024,
    parameter logic [17:0]        X_MAX          = 18'h3FFFF,
    parameter logic [17:0]        PLAYER_X0      = 18'h04000,
    parameter logic [17:0]        PLAYER_Y0      = 18'h4A800,
    parameter logic [7:0]         EXPLODE_CYCLES = 8'd102
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic          move_left,
    input  logic          move_right,
    input  logic          jump,
    input  logic          fire,
    object_mover_if.master bus,
    output logic          busy
);

    localparam logic signed [11:0] STEP_V = $signed({1'b0, STEP_X[10:0]});

    mover_state_t       state_r, state_nxt_s;
    logic [17:0]        x_r, x_nxt_s, y_r, y_nxt_s;
    logic [17:0]        shadow_x_r, shadow_x_nxt_s, shadow_y_r, shadow_y_nxt_s;
    logic signed [11:0] vy_r, vy_nxt_s, svx_r, svx_nxt_s, svy_r, svy_nxt_s;
    logic               facing_r, facing_nxt_s, settle_r, settle_nxt_s;
    logic               id_r, id_nxt_s, game_state_r, game_state_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [7:0]         cnt_r, cnt_nxt_s;

    logic [3:0]         flags_s;
    logic               right_go_s, left_go_s;
    logic signed [11:0] xv_s, yv_s, x_vel_unused_s, y_vel_s;
    logic               ygrav_s, yclip_s;
    logic [17:0]        x_pos_s, y_pos_s;
    logic               x_under_s, x_over_s, y_under_s, y_over_unused_s;

    // Flags sampled right after an id change describe the previous object.
    assign flags_s    = settle_r ? 4'b0000 : bus.object_states_in;
    assign right_go_s = move_right & ~move_left & ~flags_s[RIGHT_BLK];
    assign left_go_s  = move_left & ~move_right & ~flags_s[LEFT_BLK];

    // Axis inputs: shell ballistics in flight, player controls otherwise.
    always_comb begin
        case (state_r)
            ST_SHELL: begin
                xv_s    = svx_r;
                yv_s    = svy_r;
                ygrav_s = 1'b1;
                yclip_s = 1'b0;
            end
            default: begin
                if (right_go_s) begin
                    xv_s = STEP_V;
                end else if (left_go_s) begin
                    xv_s = -STEP_V;
                end else begin
                    xv_s = 12'sd0;
                end
                if (flags_s[SUPPORT]) begin
                    yv_s = jump ? JUMP_VY : 12'sd0;
                end else begin
                    yv_s = vy_r;
                end
                ygrav_s = ~flags_s[SUPPORT];
                yclip_s = flags_s[TOP_HIT];
            end
        endcase
    end

    motion_integrator #(
        .GRAVITY (GRAVITY),
        .VY_MIN  (VY_MIN),
        .POS_MAX (X_MAX)
    ) u_x_axis (
        .pos      (x_r),
        .vel      (xv_s),
        .grav_en  (1'b0),
        .clip_up  (1'b0),
        .vel_next (x_vel_unused_s),
        .pos_next (x_pos_s),
        .under    (x_under_s),
        .over     (x_over_s)
    );

    motion_integrator #(
        .GRAVITY (GRAVITY),
        .VY_MIN  (VY_MIN),
        .POS_MAX (18'h3FFFF)
    ) u_y_axis (
        .pos      (y_r),
        .vel      (yv_s),
        .grav_en  (ygrav_s),
        .clip_up  (yclip_s),
        .vel_next (y_vel_s),
        .pos_next (y_pos_s),
        .under    (y_under_s),
        .over     (y_over_unused_s)
    );

    // Next-state and register updates for the player/shell/explode sequence.
    always_comb begin
        state_nxt_s      = state_r;
        x_nxt_s          = x_r;
        y_nxt_s          = y_r;
        shadow_x_nxt_s   = shadow_x_r;
        shadow_y_nxt_s   = shadow_y_r;
        vy_nxt_s         = vy_r;
        svx_nxt_s        = svx_r;
        svy_nxt_s        = svy_r;
        facing_nxt_s     = facing_r;
        settle_nxt_s     = settle_r;
        id_nxt_s         = id_r;
        game_state_nxt_s = game_state_r;
        busy_nxt_s       = busy_r;
        cnt_nxt_s        = cnt_r;
        case (state_r)
            ST_PLAYER: begin
                if (fire) begin
                    shadow_x_nxt_s = x_r;
                    shadow_y_nxt_s = y_r;
                    svx_nxt_s      = facing_r ? SHELL_VX : -SHELL_VX;
                    svy_nxt_s      = SHELL_VY;
                    id_nxt_s       = 1'b0;
                    busy_nxt_s     = 1'b1;
                    settle_nxt_s   = 1'b1;
                    state_nxt_s    = ST_SHELL;
                end else if (frame_tick) begin
                    x_nxt_s      = x_pos_s;
                    y_nxt_s      = y_pos_s;
                    vy_nxt_s     = y_vel_s;
                    settle_nxt_s = 1'b0;
                    if (right_go_s) begin
                        facing_nxt_s = 1'b1;
                    end else if (left_go_s) begin
                        facing_nxt_s = 1'b0;
                    end else begin
                        facing_nxt_s = facing_r;
                    end
                end else begin
                    state_nxt_s = ST_PLAYER;
                end
            end
            ST_SHELL: begin
                if (frame_tick) begin
                    settle_nxt_s = 1'b0;
                    if (|flags_s) begin
                        game_state_nxt_s = 1'b1;
                        cnt_nxt_s        = 8'd0;
                        state_nxt_s      = ST_EXPLODE;
                    end else if (x_under_s || x_over_s || y_under_s) begin
                        x_nxt_s      = shadow_x_r;
                        y_nxt_s      = shadow_y_r;
                        id_nxt_s     = 1'b1;
                        busy_nxt_s   = 1'b0;
                        settle_nxt_s = 1'b1;
                        state_nxt_s  = ST_PLAYER;
                    end else begin
                        x_nxt_s   = x_pos_s;
                        y_nxt_s   = y_pos_s;
                        svy_nxt_s = y_vel_s;
                    end
                end else begin
                    state_nxt_s = ST_SHELL;
                end
            end
            ST_EXPLODE: begin
                if (cnt_r == (EXPLODE_CYCLES - 8'd1)) begin
                    game_state_nxt_s = 1'b0;
                    x_nxt_s          = shadow_x_r;
                    y_nxt_s          = shadow_y_r;
                    id_nxt_s         = 1'b1;
                    busy_nxt_s       = 1'b0;
                    settle_nxt_s     = 1'b1;
                    cnt_nxt_s        = 8'd0;
                    state_nxt_s      = ST_PLAYER;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_PLAYER;
            end
        endcase
    end

    // State register bank; reset restores the player at its spawn point.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_PLAYER;
            x_r          <= PLAYER_X0;
            y_r          <= PLAYER_Y0;
            shadow_x_r   <= PLAYER_X0;
            shadow_y_r   <= PLAYER_Y0;
            vy_r         <= 12'sd0;
            svx_r        <= 12'sd0;
            svy_r        <= 12'sd0;
            facing_r     <= 1'b1;
            settle_r     <= 1'b1;
            id_r         <= 1'b1;
            game_state_r <= 1'b0;
            busy_r       <= 1'b0;
            cnt_r        <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            x_r          <= x_nxt_s;
            y_r          <= y_nxt_s;
            shadow_x_r   <= shadow_x_nxt_s;
            shadow_y_r   <= shadow_y_nxt_s;
            vy_r         <= vy_nxt_s;
            svx_r        <= svx_nxt_s;
            svy_r        <= svy_nxt_s;
            facing_r     <= facing_nxt_s;
            settle_r     <= settle_nxt_s;
            id_r         <= id_nxt_s;
            game_state_r <= game_state_nxt_s;
            busy_r       <= busy_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    assign bus.object_x   = x_r;
    assign bus.object_y   = y_r;
    assign bus.id         = id_r;
    assign bus.game_state = game_state_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_object_mover.sv
// Scoreboard bench for object_mover: stimulus queues hand-computed bus
// states with the cycle they are due; a monitor pops and compares them.
module tb_object_mover;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0, move_left = 1'b0, move_right = 1'b0;
    logic jump = 1'b0, fire = 1'b0, busy;

    object_mover_if bus ();

    object_mover dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .move_left  (move_left),
        .move_right (move_right),
        .jump       (jump),
        .fire       (fire),
        .bus        (bus),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        int          due;
        logic [17:0] x;
        logic [17:0] y;
        logic        id;
        logic        gs;
        logic        bsy;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick(input logic [3:0] f);
        frame_tick = 1'b1;
        bus.object_states_in = f;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic exp_at(input string n, input int dly, input logic [17:0] x,
                          input logic [17:0] y, input logic id_e,
                          input logic gs_e, input logic b_e);
        exp_t e;
        e.name = n; e.due = cyc + dly; e.x = x; e.y = y;
        e.id = id_e; e.gs = gs_e; e.bsy = b_e;
        exp_q.push_back(e);
    endtask

    task automatic pulse_fire();
        fire = 1'b1;
        step();
        fire = 1'b0;
    endtask

    // Monitor: compares due expectations and measures game_state pulses.
    initial begin
        exp_t e;
        int   hi_len = 0;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL %s: expectation never reached (due cycle %0d, now %0d)",
                         e.name, e.due, cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.object_x !== e.x || bus.object_y !== e.y || bus.id !== e.id ||
                    bus.game_state !== e.gs || busy !== e.bsy) begin
                    errors++;
                    $display("FAIL %s: got x=%h y=%h id=%b gs=%b busy=%b, want x=%h y=%h id=%b gs=%b busy=%b",
                             e.name, bus.object_x, bus.object_y, bus.id, bus.game_state, busy,
                             e.x, e.y, e.id, e.gs, e.bsy);
                end
            end
            if (!rst_n) begin
                hi_len = 0;
            end else if (bus.game_state === 1'b1) begin
                hi_len++;
            end else if (hi_len != 0) begin
                checks++;
                if (pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL explode_pulse: unexpected game_state pulse of %0d cycles, want none", hi_len);
                end else if (hi_len != pulse_q[0]) begin
                    errors++;
                    $display("FAIL explode_pulse: got %0d cycles, want %0d", hi_len, pulse_q[0]);
                    void'(pulse_q.pop_front());
                end else begin
                    void'(pulse_q.pop_front());
                end
                hi_len = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus with hand-computed bus expectations.
    initial begin
        logic [17:0] fall_y [3];
        fall_y[0] = 18'h4A780; fall_y[1] = 18'h4A700; fall_y[2] = 18'h4A640;
        bus.object_states_in = 4'b0000;
        step(); step();
        exp_at("reset", 0, 18'h04000, 18'h4A800, 1'b1, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        tick(4'b0100);
        exp_at("settle_tick", 0, 18'h04000, 18'h4A7C0, 1'b1, 1'b0, 1'b0);
        move_right = 1'b1;
        tick(4'b0100);
        exp_at("walk_right", 0, 18'h04400, 18'h4A7C0, 1'b1, 1'b0, 1'b0);
        move_right = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick(4'b0000);
            exp_at("fall", 0, 18'h04400, fall_y[i], 1'b1, 1'b0, 1'b0);
        end
        tick(4'b0100);
        exp_at("land", 0, 18'h04400, 18'h4A640, 1'b1, 1'b0, 1'b0);
        jump = 1'b1;
        tick(4'b0100);
        exp_at("jump", 0, 18'h04400, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        jump = 1'b0;
        tick(4'b1000);
        exp_at("head_hit", 0, 18'h04400, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        tick(4'b0100);
        exp_at("rest_after_hit", 0, 18'h04400, 18'h4AC40, 1'b1, 1'b0, 1'b0);

        move_left = 1'b1;
        tick(4'b0110);
        exp_at("left_blocked", 0, 18'h04400, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        tick(4'b0100);
        exp_at("walk_left", 0, 18'h04000, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        move_right = 1'b1;
        tick(4'b0100);
        exp_at("both_keys", 0, 18'h04000, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        move_right = 1'b0;
        for (int i = 0; i < 16; i++) tick(4'b0100);
        exp_at("left_to_zero", 0, 18'h00000, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        tick(4'b0100);
        exp_at("sat_zero", 0, 18'h00000, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        move_left = 1'b0;

        move_right = 1'b1;
        tick(4'b0101);
        exp_at("right_blocked", 0, 18'h00000, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) tick(4'b0100);
        exp_at("walk_to_10000", 0, 18'h10000, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        move_right = 1'b0;

        pulse_fire();
        exp_at("fire", 0, 18'h10000, 18'h4AC40, 1'b0, 1'b0, 1'b1);
        tick(4'b1111);
        exp_at("shell_settle", 0, 18'h10300, 18'h4B000, 1'b0, 1'b0, 1'b1);
        pulse_fire();
        exp_at("fire_ignored", 0, 18'h10300, 18'h4B000, 1'b0, 1'b0, 1'b1);

        tick(4'b0001);
        pulse_q.push_back(102);
        exp_at("explode", 0, 18'h10300, 18'h4B000, 1'b0, 1'b1, 1'b1);
        exp_at("explode_mid", 50, 18'h10300, 18'h4B000, 1'b0, 1'b1, 1'b1);
        exp_at("explode_last", 101, 18'h10300, 18'h4B000, 1'b0, 1'b1, 1'b1);
        exp_at("explode_end", 102, 18'h10000, 18'h4AC40, 1'b1, 1'b0, 1'b0);
        repeat (102) step();

        tick(4'b0100);
        exp_at("settle_after_explode", 0, 18'h10000, 18'h4AC00, 1'b1, 1'b0, 1'b0);
        move_right = 1'b1;
        for (int i = 0; i < 191; i++) tick(4'b0100);
        exp_at("walk_to_3fc00", 0, 18'h3FC00, 18'h4AC00, 1'b1, 1'b0, 1'b0);
        move_right = 1'b0;

        pulse_fire();
        exp_at("fire2", 0, 18'h3FC00, 18'h4AC00, 1'b0, 1'b0, 1'b1);
        tick(4'b0000);
        exp_at("shell_edge", 0, 18'h3FF00, 18'h4AFC0, 1'b0, 1'b0, 1'b1);
        tick(4'b0000);
        exp_at("despawn", 0, 18'h3FC00, 18'h4AC00, 1'b1, 1'b0, 1'b0);
        step();

        move_right = 1'b1;
        tick(4'b0100);
        exp_at("sat_right", 0, 18'h3FFFF, 18'h4ABC0, 1'b1, 1'b0, 1'b0);
        tick(4'b0100);
        exp_at("sat_right_hold", 0, 18'h3FFFF, 18'h4ABC0, 1'b1, 1'b0, 1'b0);
        move_right = 1'b0;
        move_left = 1'b1;
        tick(4'b0100);
        exp_at("walk_left2", 0, 18'h3FBFF, 18'h4ABC0, 1'b1, 1'b0, 1'b0);
        move_left = 1'b0;

        pulse_fire();
        exp_at("fire3", 0, 18'h3FBFF, 18'h4ABC0, 1'b0, 1'b0, 1'b1);
        tick(4'b0000);
        exp_at("shell_left", 0, 18'h3F8FF, 18'h4AF80, 1'b0, 1'b0, 1'b1);
        tick(4'b0010);
        exp_at("explode2", 0, 18'h3F8FF, 18'h4AF80, 1'b0, 1'b1, 1'b1);
        repeat (40) step();
        rst_n = 1'b0;
        exp_at("reset_mid_explode", 0, 18'h04000, 18'h4A800, 1'b1, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        tick(4'b0100);
        exp_at("post_reset", 0, 18'h04000, 18'h4A7C0, 1'b1, 1'b0, 1'b0);
        repeat (3) step();

        checks++;
        if (exp_q.size() != 0 || pulse_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expectations and %0d pulses pending, want 0 and 0",
                     exp_q.size(), pulse_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
